// File: rtl/instr_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_loader_pkg
//   Shared definitions for the boot-time instruction loader.
//   - HDR_W        : width of the big-endian program-length header (bytes x 8)
//   - load_state_e : loader state encoding
//   - is_loading() : true in the states where the loader consumes bytes
// -----------------------------------------------------------------------------
package instr_loader_pkg;

    localparam int HDR_W = 16;

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
        CHK    = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } load_state_e;

    // The loader only takes bytes while a load is still in progress;
    // DONE and ERR are terminal until a reload request arrives.
    function automatic logic is_loading(input load_state_e s);
        return (s == HDR_HI) || (s == HDR_LO) || (s == DATA) || (s == CHK);
    endfunction

endpackage

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Receives a program over a byte stream and writes it into instruction
//   memory, holding the CPU in reset until a load finishes with a good
//   checksum.  Stream format:
//       LEN_HI LEN_LO | N words, 4 bytes each, big-endian | XOR checksum
//   The checksum is the XOR of every data byte (header bytes excluded).
//
// Parameters
//   BASE_ADDR   : byte address written for word 0
//   MAX_WORDS   : longest program accepted; larger headers abort the load
//
// Ports
//   clk_i        in   1  clock, rising edge
//   rst_i        in   1  asynchronous active-high reset
//   rx_data_i    in   8  incoming byte
//   rx_valid_i   in   1  rx_data_i valid
//   rx_ready_o   out  1  byte accepted when rx_valid_i & rx_ready_o
//   start_i      in   1  reload request, honoured only in DONE / ERR
//   im_we_o      out  1  one-cycle instruction-memory write strobe
//   im_addr_o    out 32  write byte address (held between writes)
//   im_data_o    out 32  write data (held between writes)
//   cpu_rst_n_o  out  1  CPU released (1) only in DONE
//   done_o       out  1  load complete, checksum good
//   err_o        out  1  load aborted
// -----------------------------------------------------------------------------
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    input  logic        start_i,
    output logic        im_we_o,
    output logic [31:0] im_addr_o,
    output logic [31:0] im_data_o,
    output logic        cpu_rst_n_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [HDR_W-1:0] MAX_LEN = HDR_W'(MAX_WORDS);

    load_state_e      state_q, state_d;
    logic             live_q;
    logic [HDR_W-1:0] len_q, len_d;
    logic [HDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [23:0]      shift_q, shift_d;
    logic [7:0]       xor_q, xor_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;

    logic             accept;
    logic [HDR_W-1:0] hdr_len;

    // live_q keeps rx_ready_o low while reset is held and lets it rise on
    // the first clock edge after reset is released.
    assign rx_ready_o  = live_q && is_loading(state_q);
    assign accept      = rx_valid_i && rx_ready_o;
    assign hdr_len     = {len_q[HDR_W-1:8], rx_data_i};

    assign im_we_o     = we_q;
    assign im_addr_o   = addr_q;
    assign im_data_o   = data_q;
    assign cpu_rst_n_o = (state_q == DONE);
    assign done_o      = (state_q == DONE);
    assign err_o       = (state_q == ERR);

    // Next-state and datapath logic.  The write strobe is registered, so the
    // word appears on the memory port in the cycle after its fourth byte;
    // rx_ready_o stays up through that cycle so streaming never stalls.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        xor_d      = xor_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;

        case (state_q)
            HDR_HI: begin
                if (accept) begin
                    len_d   = {rx_data_i, len_q[7:0]};
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    len_d = hdr_len;
                    if (hdr_len == '0) begin
                        state_d = CHK;
                    end else if (hdr_len > MAX_LEN) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    xor_d = xor_q ^ rx_data_i;
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = BASE_ADDR + {{(32-HDR_W-2){1'b0}}, word_cnt_q, 2'b00};
                        data_d     = {shift_q, rx_data_i};
                        byte_cnt_d = 2'd0;
                        word_cnt_d = word_cnt_q + HDR_W'(1);
                        if (word_cnt_q == len_q - HDR_W'(1)) begin
                            state_d = CHK;
                        end
                    end else begin
                        shift_d    = {shift_q[15:0], rx_data_i};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            CHK: begin
                if (accept) begin
                    state_d = (rx_data_i == xor_q) ? DONE : ERR;
                end
            end
            DONE, ERR: begin
                if (start_i) begin
                    word_cnt_d = '0;
                    byte_cnt_d = 2'd0;
                    xor_d      = 8'h00;
                    state_d    = HDR_HI;
                end
            end
            default: begin
                state_d = HDR_HI;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= HDR_HI;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.  Reset drops any partially packed word, so an
    // interrupted load never writes a half-assembled instruction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            live_q     <= 1'b0;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'h0;
            xor_q      <= 8'h00;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            data_q     <= 32'h0;
        end else begin
            live_q     <= 1'b1;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            xor_q      <= xor_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//   Self-checking bench for instr_loader: a table of directed loads, hand
//   sequences for abort and reload, and randomized loads compared against a
//   byte-stream model of the load protocol.
// -----------------------------------------------------------------------------
module tb_instr_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 128;

    typedef logic [7:0] byteQ_t[$];

    typedef struct packed {
        logic [7:0]   nBytes;
        logic [127:0] stream;
        logic         stall;
        logic [7:0]   startAt;
        logic         expDone;
        logic         expErr;
        logic [1:0]   nWr;
        logic [31:0]  a0;
        logic [31:0]  d0;
        logic [31:0]  a1;
        logic [31:0]  d1;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic        startI;
    logic        imWe;
    logic [31:0] imAddr;
    logic [31:0] imData;
    logic        cpuRstN;
    logic        doneO;
    logic        errO;

    int          vecCount  = 0;
    int          missCount = 0;

    logic [31:0] wrAddrQ[$];
    logic [31:0] wrDataQ[$];
    logic [31:0] expAddrQ[$];
    logic [31:0] expDataQ[$];
    logic        expDone;
    logic        expErr;
    logic [31:0] holdAddr;
    logic [31:0] holdData;

    vec_t        vecs[6];
    byteQ_t      stim;

    instr_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_data_i   (rxData),
        .rx_valid_i  (rxValid),
        .rx_ready_o  (rxReady),
        .start_i     (startI),
        .im_we_o     (imWe),
        .im_addr_o   (imAddr),
        .im_data_o   (imData),
        .cpu_rst_n_o (cpuRstN),
        .done_o      (doneO),
        .err_o       (errO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every memory write, one entry per cycle the strobe is high.
    always @(negedge clk) begin
        if (!rst && imWe) begin
            wrAddrQ.push_back(imAddr);
            wrDataQ.push_back(imData);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Offer one byte and hold it until the loader takes it.  With stall set,
    // rx_valid is dropped for one cycle first.
    task automatic applyStimulus(input logic [7:0] b, input bit stall, input bit withStart);
        int n = 0;
        if (stall) begin
            rxValid = 1'b0;
            @(negedge clk);
        end
        rxData  = b;
        rxValid = 1'b1;
        startI  = withStart;
        while (!rxReady && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rxReady) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL accept timeout: rx_ready got %b, required 1", rxReady);
        end else begin
            @(negedge clk);
        end
        rxValid = 1'b0;
        startI  = 1'b0;
    endtask

    task automatic doReset();
        rxValid  = 1'b0;
        startI   = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        @(negedge clk);
        holdAddr = BASE;
        holdData = 32'h0;
    endtask

    // Protocol model: decides how many bytes the loader should take and what
    // it should write, purely from the stream contents.
    task automatic modelLoad(input byteQ_t s, output int consumed);
        int          n;
        logic [7:0]  x;
        logic [31:0] w;
        expAddrQ.delete();
        expDataQ.delete();
        n = int'({s[0], s[1]});
        if (n > MAXW) begin
            consumed = 2;
            expDone  = 1'b0;
            expErr   = 1'b1;
        end else begin
            x = 8'h00;
            for (int k = 0; k < n; k++) begin
                w = {s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]};
                expAddrQ.push_back(BASE + 32'(4 * k));
                expDataQ.push_back(w);
                x = x ^ s[2+4*k] ^ s[3+4*k] ^ s[4+4*k] ^ s[5+4*k];
            end
            consumed = 3 + 4 * n;
            expDone  = (s[2+4*n] == x);
            expErr   = !expDone;
        end
    endtask

    task automatic sendAndCompare(input byteQ_t s, input int consumed, input bit stall,
                                  input int startAt, input string name);
        wrAddrQ.delete();
        wrDataQ.delete();
        for (int j = 0; j < consumed; j++) begin
            applyStimulus(s[j], stall, j == startAt);
        end
        repeat (2) @(negedge clk);
        checkOutput({name, " done"}, 32'(doneO), 32'(expDone));
        checkOutput({name, " err"}, 32'(errO), 32'(expErr));
        checkOutput({name, " cpu_rst_n"}, 32'(cpuRstN), 32'(expDone));
        checkOutput({name, " rx_ready"}, 32'(rxReady), 32'h0);
        checkOutput({name, " write count"}, 32'(wrAddrQ.size()), 32'(expAddrQ.size()));
        for (int j = 0; j < expAddrQ.size(); j++) begin
            if (j < wrAddrQ.size()) begin
                checkOutput({name, " write addr"}, wrAddrQ[j], expAddrQ[j]);
                checkOutput({name, " write data"}, wrDataQ[j], expDataQ[j]);
            end
        end
        if (expAddrQ.size() > 0) begin
            holdAddr = expAddrQ[$];
            holdData = expDataQ[$];
        end
        checkOutput({name, " held addr"}, imAddr, holdAddr);
        checkOutput({name, " held data"}, imData, holdData);
    endtask

    task automatic pulseStart();
        startI = 1'b1;
        @(negedge clk);
        startI = 1'b0;
    endtask

    initial begin
        int          consumed;
        int          n;
        logic [7:0]  x;
        logic [7:0]  b;
        bit          stall;
        int          startAt;

        // Directed loads.  0x4D is the XOR of the nominal data bytes
        // 20 08 00 05 00 00 40 20; 0x21 is a wrong checksum for them.
        vecs[0] = '{nBytes: 8'd11, stream: {88'h0002_2008_0005_0000_4020_4D, 40'h0},
                    stall: 1'b0, startAt: 8'hFF, expDone: 1'b1, expErr: 1'b0, nWr: 2'd2,
                    a0: 32'h0, d0: 32'h2008_0005, a1: 32'h4, d1: 32'h0000_4020};
        vecs[1] = '{nBytes: 8'd11, stream: {88'h0002_2008_0005_0000_4020_21, 40'h0},
                    stall: 1'b0, startAt: 8'hFF, expDone: 1'b0, expErr: 1'b1, nWr: 2'd2,
                    a0: 32'h0, d0: 32'h2008_0005, a1: 32'h4, d1: 32'h0000_4020};
        vecs[2] = '{nBytes: 8'd2, stream: {16'h0081, 112'h0},
                    stall: 1'b0, startAt: 8'hFF, expDone: 1'b0, expErr: 1'b1, nWr: 2'd0,
                    a0: 32'h0, d0: 32'h0, a1: 32'h0, d1: 32'h0};
        vecs[3] = '{nBytes: 8'd3, stream: {24'h000000, 104'h0},
                    stall: 1'b0, startAt: 8'hFF, expDone: 1'b1, expErr: 1'b0, nWr: 2'd0,
                    a0: 32'h0, d0: 32'h0, a1: 32'h0, d1: 32'h0};
        vecs[4] = '{nBytes: 8'd11, stream: {88'h0002_2008_0005_0000_4020_4D, 40'h0},
                    stall: 1'b1, startAt: 8'hFF, expDone: 1'b1, expErr: 1'b0, nWr: 2'd2,
                    a0: 32'h0, d0: 32'h2008_0005, a1: 32'h4, d1: 32'h0000_4020};
        vecs[5] = '{nBytes: 8'd11, stream: {88'h0002_2008_0005_0000_4020_4D, 40'h0},
                    stall: 1'b0, startAt: 8'd5, expDone: 1'b1, expErr: 1'b0, nWr: 2'd2,
                    a0: 32'h0, d0: 32'h2008_0005, a1: 32'h4, d1: 32'h0000_4020};

        rst     = 1'b1;
        rxData  = 8'h00;
        rxValid = 1'b0;
        startI  = 1'b0;

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        checkOutput("reset im_we", 32'(imWe), 32'h0);
        checkOutput("reset im_addr", imAddr, BASE);
        checkOutput("reset im_data", imData, 32'h0);
        checkOutput("reset cpu_rst_n", 32'(cpuRstN), 32'h0);
        checkOutput("reset done", 32'(doneO), 32'h0);
        checkOutput("reset err", 32'(errO), 32'h0);
        checkOutput("reset rx_ready", 32'(rxReady), 32'h0);
        rst = 1'b0;
        #1;
        checkOutput("rx_ready before first edge", 32'(rxReady), 32'h0);
        @(negedge clk);
        checkOutput("rx_ready after first edge", 32'(rxReady), 32'h1);

        // Table-driven directed loads, each from a fresh reset.
        for (int i = 0; i < 6; i++) begin
            doReset();
            stim.delete();
            for (int j = 0; j < int'(vecs[i].nBytes); j++) begin
                stim.push_back(vecs[i].stream[127-8*j -: 8]);
            end
            expAddrQ.delete();
            expDataQ.delete();
            if (vecs[i].nWr >= 2'd1) begin
                expAddrQ.push_back(vecs[i].a0);
                expDataQ.push_back(vecs[i].d0);
            end
            if (vecs[i].nWr == 2'd2) begin
                expAddrQ.push_back(vecs[i].a1);
                expDataQ.push_back(vecs[i].d1);
            end
            expDone = vecs[i].expDone;
            expErr  = vecs[i].expErr;
            sendAndCompare(stim, int'(vecs[i].nBytes), vecs[i].stall,
                           int'(vecs[i].startAt), $sformatf("vec%0d", i));
        end

        // Reload from DONE: CPU goes back into reset at once, then a
        // one-word program lands at the base address.
        pulseStart();
        checkOutput("reload cpu_rst_n", 32'(cpuRstN), 32'h0);
        checkOutput("reload done", 32'(doneO), 32'h0);
        checkOutput("reload rx_ready", 32'(rxReady), 32'h1);
        stim = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        expAddrQ = '{32'h0};
        expDataQ = '{32'h1122_3344};
        expDone  = 1'b1;
        expErr   = 1'b0;
        sendAndCompare(stim, 7, 1'b0, -1, "reload");

        // Abort: reset after six data bytes; only word 0 may be written.
        doReset();
        wrAddrQ.delete();
        wrDataQ.delete();
        stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00};
        for (int j = 0; j < 8; j++) applyStimulus(stim[j], 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort im_we", 32'(imWe), 32'h0);
        checkOutput("abort im_data", imData, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort write count", 32'(wrAddrQ.size()), 32'h1);
        if (wrAddrQ.size() > 0) begin
            checkOutput("abort word0 addr", wrAddrQ[0], 32'h0);
            checkOutput("abort word0 data", wrDataQ[0], 32'h2008_0005);
        end
        holdAddr = BASE;
        holdData = 32'h0;
        stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h40, 8'h20, 8'h4D};
        modelLoad(stim, consumed);
        sendAndCompare(stim, consumed, 1'b0, -1, "after abort");

        // Randomized loads, chained through start_i.
        for (int it = 0; it < 24; it++) begin
            pulseStart();
            checkOutput("rand restart cpu_rst_n", 32'(cpuRstN), 32'h0);
            checkOutput("rand restart rx_ready", 32'(rxReady), 32'h1);
            if ($urandom_range(0, 7) == 0) begin
                n = 129 + int'($urandom_range(0, 100));
            end else begin
                n = int'($urandom_range(0, 6));
            end
            stim.delete();
            stim.push_back(8'(n >> 8));
            stim.push_back(8'(n));
            x = 8'h00;
            if (n <= MAXW) begin
                for (int k = 0; k < 4 * n; k++) begin
                    b = 8'($urandom);
                    x = x ^ b;
                    stim.push_back(b);
                end
                if ($urandom_range(0, 3) == 0) begin
                    x = x ^ (8'h01 << $urandom_range(0, 7));
                end
                stim.push_back(x);
            end
            stall   = bit'($urandom_range(0, 1));
            startAt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6)) : -1;
            modelLoad(stim, consumed);
            sendAndCompare(stim, consumed, stall, startAt, $sformatf("rand%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
